// File: rtl/local_predictor_bank.sv
// rtl/local_predictor_bank.sv - four local tables of 2-bit saturating branch counters
module local_predictor_bank #(
  parameter int INDEX_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             LocalSrc,
  input  logic [INDEX_WIDTH-1:0] PCIndexF,
  input  logic [INDEX_WIDTH-1:0] PCIndexE,
  input  logic                   BranchOpEb0,
  input  logic                   PCSrcResE,
  output logic                   PredTakenF
);

  // The four tables are stored as one flat array addressed by {table, index}.
  localparam int ADDR_W = INDEX_WIDTH + 2;
  localparam int DEPTH  = 1 << ADDR_W;

  localparam logic [1:0] CNT_SN = 2'b00;
  localparam logic [1:0] CNT_WN = 2'b01;
  localparam logic [1:0] CNT_ST = 2'b11;

  logic [1:0]        cnt_q [DEPTH];
  logic [1:0]        upd_cnt_d;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;

  assign rd_addr = {LocalSrc, PCIndexF};
  assign wr_addr = {LocalSrc, PCIndexE};

  // No bypass: a same-cycle update only becomes visible after the edge.
  assign PredTakenF = cnt_q[rd_addr][1];

  // Saturating step of the counter addressed by the resolving branch.
  always_comb begin
    upd_cnt_d = cnt_q[wr_addr];
    if (PCSrcResE) begin
      if (cnt_q[wr_addr] != CNT_ST) upd_cnt_d = cnt_q[wr_addr] + 2'b01;
    end else begin
      if (cnt_q[wr_addr] != CNT_SN) upd_cnt_d = cnt_q[wr_addr] - 2'b01;
    end
  end

  // Reset all counters to weakly untaken; otherwise train one counter per resolved branch.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= CNT_WN;
    end else if (BranchOpEb0) begin
      cnt_q[wr_addr] <= upd_cnt_d;
    end
  end

endmodule

// File: tb/tb_local_predictor_bank.sv
// tb/tb_local_predictor_bank.sv - directed table-driven bench for local_predictor_bank
module tb_local_predictor_bank;

  logic       clk;
  logic       reset;
  logic [1:0] LocalSrc;
  logic [4:0] PCIndexF;
  logic [4:0] PCIndexE;
  logic       BranchOpEb0;
  logic       PCSrcResE;
  logic       PredTakenF;

  int total = 0;
  int bad   = 0;

  local_predictor_bank #(.INDEX_WIDTH(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .LocalSrc   (LocalSrc),
    .PCIndexF   (PCIndexF),
    .PCIndexE   (PCIndexE),
    .BranchOpEb0(BranchOpEb0),
    .PCSrcResE  (PCSrcResE),
    .PredTakenF (PredTakenF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // exp is the PredTakenF value during the cycle, before the edge that applies the inputs.
  typedef struct {
    logic       rst;
    logic [1:0] src;
    logic [4:0] f;
    logic [4:0] e;
    logic       br;
    logic       tk;
    logic       exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [1:0] s, input logic [4:0] f, input logic [4:0] e,
                     input logic br, input logic tk, input logic exp);
    vec_t t;
    t.rst = r; t.src = s; t.f = f; t.e = e; t.br = br; t.tk = tk; t.exp = exp;
    vecs.push_back(t);
  endtask

  task automatic check(input string tag, input int idx, input logic exp);
    total++;
    if (PredTakenF !== exp) begin
      bad++;
      $display("FAIL %s[%0d] PredTakenF=%b expected=%b", tag, idx, PredTakenF, exp);
    end
  endtask

  task automatic apply(input string tag, input int idx, input vec_t t);
    @(negedge clk);
    reset = t.rst; LocalSrc = t.src; PCIndexF = t.f; PCIndexE = t.e;
    BranchOpEb0 = t.br; PCSrcResE = t.tk;
    #1;
    check(tag, idx, t.exp);
  endtask

  initial begin
    reset = 1'b0; LocalSrc = 2'd0; PCIndexF = 5'd0; PCIndexE = 5'd0;
    BranchOpEb0 = 1'b0; PCSrcResE = 1'b0;

    // one-cycle reset
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // reset sweep over every table and index
    for (int s = 0; s < 4; s++) begin
      for (int f = 0; f < 32; f++) begin
        LocalSrc = 2'(s);
        PCIndexF = 5'(f);
        #1;
        check("reset_sweep", s * 32 + f, 1'b0);
      end
    end

    // training up on table 1 index 5: 01 -> 10 -> 11 -> 11 -> 11
    add(0, 1, 5, 5, 1, 1, 0);
    add(0, 1, 5, 5, 1, 1, 1);
    add(0, 1, 5, 5, 1, 1, 1);
    add(0, 1, 5, 5, 1, 1, 1);
    // training down: 11 -> 10 -> 01 -> 00 -> 00
    add(0, 1, 5, 5, 1, 0, 1);
    add(0, 1, 5, 5, 1, 0, 1);
    add(0, 1, 5, 5, 1, 0, 0);
    add(0, 1, 5, 5, 1, 0, 0);
    add(0, 1, 5, 5, 0, 1, 0);
    // table 2 index 9 trained to 11, then isolation probes
    add(0, 2, 9, 9, 1, 1, 0);
    add(0, 2, 9, 9, 1, 1, 1);
    add(0, 2, 9, 9, 0, 0, 1);
    add(0, 0, 9, 9, 0, 0, 0);
    add(0, 1, 9, 9, 0, 0, 0);
    add(0, 3, 9, 9, 0, 0, 0);
    add(0, 2, 10, 9, 0, 0, 0);
    // update of a neighbouring index leaves the read entry alone
    add(0, 2, 9, 10, 1, 0, 1);
    add(0, 2, 9, 10, 0, 0, 1);
    add(0, 2, 10, 10, 0, 1, 0);
    // bring table 3 index 7 to 10 so gating probes sit on both sides of the threshold
    add(0, 3, 7, 7, 1, 1, 0);
    add(0, 3, 7, 7, 0, 0, 1);
    add(0, 0, 7, 7, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) apply("train", i, vecs[i]);

    // enable gating: any leaked update flips a probed prediction
    for (int i = 0; i < 32; i++) begin
      vec_t t;
      t.rst = 0; t.br = 0; t.f = 5'd7; t.e = 5'd7;
      t.src = i[0] ? 2'd3 : 2'd0;
      t.tk  = ((i / 4) % 2) == 1;
      t.exp = i[0];
      apply("gating", i, t);
    end

    // collision on fresh entry table 0 index 20, then reset with a concurrent update
    begin
      vec_t t;
      t.rst = 0; t.src = 0; t.f = 20; t.e = 20; t.br = 1; t.tk = 1; t.exp = 0;
      apply("collision", 0, t);
      t.br = 0; t.exp = 1;
      apply("collision", 1, t);
      t.rst = 1; t.br = 1; t.tk = 1; t.exp = 1;
      apply("reset_prio", 0, t);
      t.rst = 0; t.br = 0; t.exp = 0;
      apply("reset_prio", 1, t);
      t.src = 2; t.f = 9; t.e = 9; t.exp = 0;
      apply("reset_prio", 2, t);
      t.src = 3; t.f = 7; t.e = 7; t.exp = 0;
      apply("reset_prio", 3, t);
      // one increment from reset value must cross to predict-taken
      t.src = 0; t.f = 20; t.e = 20; t.br = 1; t.tk = 1; t.exp = 0;
      apply("reset_prio", 4, t);
      t.br = 0; t.exp = 1;
      apply("reset_prio", 5, t);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
